// File: rtl/i2s_tx.sv
// i2s_tx: serialises 16-bit mono samples into a two-slot I2S stream.
// The same sample goes to the left and right slots. Samples arrive through a
// single-entry holding register with a valid/ready handshake. A frame that
// starts with an empty holding register is sent as zeros, and underrun pulses.
//
// Ports:
//   clk_12        master clock; all logic runs on its rising edge
//   rst           asynchronous, active-high reset
//   en            enable streaming; dropping it finishes the current frame
//   sample_in     sample word; low DATA_W bits are the signed sample
//   in_valid      sample_in is valid
//   in_ready      holding register is empty
//   bclk          I2S bit clock
//   lrclk         I2S word select (0 = left, 1 = right)
//   sdata         I2S serial data, MSB first, with a one-bit delay
//   underrun      1-cycle pulse when a frame starts without a sample
//   busy          streaming or draining
//   underrun_cnt  saturating count of underrun pulses
//                 (only when I2S_UNDERRUN_CNT_EN is defined)
module i2s_tx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SLOT_W    = 32,
    parameter int unsigned BCLK_HALF = 2
) (
    input  logic        clk_12,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] sample_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun,
    output logic        busy
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DATA_B   = BIT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    b_q, b_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic                underrun_q, underrun_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                full_q, full_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   frame_q, frame_d;

    // Bit map of the next bit index: slot select and serial bit.
    logic [BIT_W-1:0]    b_inc;
    logic [BIT_W-1:0]    pos;
    logic [IDX_W-1:0]    bit_idx;
    logic                slot_nxt;
    logic                bit_nxt;
    logic                frame_start;
    logic                unused_sample_bits;

    assign unused_sample_bits = ^sample_in[31:DATA_W];

    always_comb begin
        b_inc    = b_q + BIT_W'(1);
        slot_nxt = (b_inc >= SLOT_B);
        pos      = slot_nxt ? (b_inc - SLOT_B) : b_inc;
        bit_idx  = IDX_W'(DATA_B - pos);
        bit_nxt  = (pos >= BIT_W'(1)) && (pos <= DATA_B) ? frame_q[bit_idx] : 1'b0;
    end

    // Next-state, counters, handshake and output computation.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        b_d         = b_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;
        full_d      = full_q;
        hold_d      = hold_q;
        frame_d     = frame_q;
        frame_start = 1'b0;

        if (in_valid && !full_q) begin
            hold_d = sample_in[DATA_W-1:0];
            full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                div_d   = '0;
                b_d     = '0;
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                if (en) begin
                    state_d     = RUN;
                    frame_start = 1'b1;
                end
            end
            default: begin
                if (state_q == RUN && !en) begin
                    state_d = DRAIN;
                end else if (state_q == DRAIN && en) begin
                    state_d = RUN;
                end
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // Falling bclk edge: advance bit index, update lrclk/sdata.
                    if (bclk_q) begin
                        if (b_q == BIT_LAST) begin
                            b_d     = '0;
                            lrclk_d = 1'b0;
                            sdata_d = 1'b0;
                            if (state_q == DRAIN && !en) begin
                                state_d = IDLE;
                            end else begin
                                frame_start = 1'b1;
                            end
                        end else begin
                            b_d     = b_inc;
                            lrclk_d = slot_nxt;
                            sdata_d = bit_nxt;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        endcase

        // Frame start: take the held sample, or send zeros and flag underrun.
        if (frame_start) begin
            if (full_q) begin
                frame_d = hold_q;
                full_d  = 1'b0;
            end else begin
                frame_d    = '0;
                underrun_d = 1'b1;
            end
        end

        busy_d     = (state_d != IDLE);
        in_ready_d = ~full_d;
    end

    // State and output registers.
    always_ff @(posedge clk_12 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            b_q        <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            full_q     <= 1'b0;
            hold_q     <= '0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            b_q        <= b_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            full_q     <= full_d;
            hold_q     <= hold_d;
            frame_q    <= frame_d;
        end
    end

    assign in_ready = in_ready_q;
    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;
    assign busy     = busy_q;

`ifdef I2S_UNDERRUN_CNT_EN
    // Saturating underrun counter.
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_12 or posedge rst) begin
        if (rst) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: table of per-frame vectors plus directed
// sequences for back-pressure, drain, drain-resume and mid-frame reset.
module tb_i2s_tx;

    logic        clk_12 = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] sample_in;
    logic        in_valid;
    logic        in_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
    logic        busy;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    i2s_tx dut (
        .clk_12   (clk_12),
        .rst      (rst),
        .en       (en),
        .sample_in(sample_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun),
        .busy     (busy)
`ifdef I2S_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk_12 = ~clk_12;

    typedef struct {
        logic        push;
        logic [31:0] smp;
        logic        exp_ur;
        logic [63:0] exp_sd;
    } vec_t;

    vec_t tab [7];

    localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

    task automatic tick();
        @(posedge clk_12);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Capture one 256-cycle frame starting at its first cycle; optionally
    // offer a sample on that first cycle.
    task automatic capture(input logic push, input logic [31:0] smp,
                           output logic [63:0] sd, output logic [63:0] lr,
                           output logic [63:0] bc);
        logic lo;
        sd = '0;
        lr = '0;
        bc = '0;
        lo = 1'b0;
        for (int b = 0; b < 64; b++) begin
            sd = {sd[62:0], sdata};
            lr = {lr[62:0], lrclk};
            for (int k = 0; k < 4; k++) begin
                if (k == 0) lo = ~bclk;
                if (k == 2) bc = {bc[62:0], bclk & lo};
                if (b == 0 && k == 0 && push) begin
                    in_valid  = 1'b1;
                    sample_in = smp;
                end
                tick();
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [63:0] sd, lr, bc;
        int n;

        // Each entry: expectations for this frame, sample offered for the next.
        tab[0] = '{1'b1, 32'hDEAD_A5A5, 1'b0, 64'h40008000_40008000};
        tab[1] = '{1'b0, 32'h0000_0000, 1'b0, 64'h52D28000_52D28000};
        tab[2] = '{1'b1, 32'h0000_7FFF, 1'b1, 64'h00000000_00000000};
        tab[3] = '{1'b1, 32'h0000_FFFF, 1'b0, 64'h3FFF8000_3FFF8000};
        tab[4] = '{1'b0, 32'h0000_0000, 1'b0, 64'h7FFF8000_7FFF8000};
        tab[5] = '{1'b0, 32'h0000_0000, 1'b1, 64'h00000000_00000000};
        tab[6] = '{1'b0, 32'h0000_0000, 1'b1, 64'h00000000_00000000};

        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        sample_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_outputs", 64'({bclk, lrclk, sdata, underrun, busy, in_ready}), 64'b000001);

        // Pre-load in IDLE, then start streaming.
        in_valid  = 1'b1;
        sample_in = 32'h0000_8001;
        tick();
        in_valid = 1'b0;
        chk("preload_full", 64'(in_ready), 64'd0);
        en = 1'b1;
        tick();
        chk("first_frame_start", 64'({busy, underrun, in_ready, bclk}), 64'b1010);

        for (int i = 0; i < 7; i++) begin
            chk($sformatf("ur_f%0d", i), 64'(underrun), 64'(tab[i].exp_ur));
            capture(tab[i].push, tab[i].smp, sd, lr, bc);
            chk($sformatf("sdata_f%0d", i), sd, tab[i].exp_sd);
            chk($sformatf("lrclk_f%0d", i), lr, LR_EXP);
            chk($sformatf("bclk_f%0d", i), bc, 64'hFFFFFFFF_FFFFFFFF);
        end

        // Back-pressure: second sample waits for the next frame start.
        chk("ur_f7", 64'(underrun), 64'd1);
        in_valid  = 1'b1;
        sample_in = 32'h0000_1111;
        tick();
        chk("full_blocks", 64'(in_ready), 64'd0);
        sample_in = 32'h0000_1234;
        n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        chk("ready_wait", 64'(n), 64'd255);
        chk("ur_f8", 64'(underrun), 64'd0);
        capture(1'b1, 32'h0000_1234, sd, lr, bc);
        chk("sdata_f8", sd, 64'h08888000_08888000);
        chk("ur_f9", 64'(underrun), 64'd0);
        capture(1'b0, 32'h0, sd, lr, bc);
        chk("sdata_f9", sd, 64'h091A0000_091A0000);

        // Drain: drop en at b=10, frame completes then idles.
        chk("ur_f10", 64'(underrun), 64'd1);
        repeat (40) tick();
        en = 1'b0;
        n  = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("drain_len", 64'(n), 64'd216);
        chk("drain_idle_out", 64'({bclk, lrclk, sdata, underrun}), 64'd0);
        repeat (8) tick();
        chk("stay_idle", 64'({busy, bclk, lrclk, sdata}), 64'd0);

        // Drain re-enabled mid-frame: no gap at the frame boundary.
        en = 1'b1;
        tick();
        chk("restart", 64'({busy, underrun}), 64'b11);
        repeat (100) tick();
        en = 1'b0;
        repeat (20) tick();
        en = 1'b1;
        repeat (136) tick();
        chk("resume_no_gap", 64'({busy, underrun, bclk}), 64'b110);

        // Mid-frame reset with a 0x7FFF frame and a held sample.
        in_valid  = 1'b1;
        sample_in = 32'h0000_7FFF;
        tick();
        in_valid = 1'b0;
        repeat (255) tick();
        chk("ur_7fff", 64'(underrun), 64'd0);
        in_valid  = 1'b1;
        sample_in = 32'h0000_2222;
        tick();
        in_valid = 1'b0;
        chk("held_full", 64'(in_ready), 64'd0);
        repeat (159) tick();
        chk("b40_bits", 64'({lrclk, sdata}), 64'b11);
        rst = 1'b1;
        #1;
        chk("async_reset", 64'({bclk, lrclk, sdata, underrun, busy, in_ready}), 64'b000001);
        en = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("post_reset_idle", 64'({busy, in_ready}), 64'b01);
        en = 1'b1;
        tick();
        chk("post_reset_ur", 64'({busy, underrun}), 64'b11);
        capture(1'b0, 32'h0, sd, lr, bc);
        chk("post_reset_zero", sd, 64'd0);
        chk("ur_empty2", 64'(underrun), 64'd1);
        capture(1'b0, 32'h0, sd, lr, bc);
        chk("ur_empty3", 64'(underrun), 64'd1);
`ifdef I2S_UNDERRUN_CNT_EN
        chk("ur_cnt3", 64'(underrun_cnt), 64'd3);
        rst = 1'b1;
        #1;
        chk("ur_cnt_reset", 64'(underrun_cnt), 64'd0);
        tick();
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
